ring_nic: RTL and testbench

- Network interface controller between one processing element and the PE port of a two-way ring router.
- Provides a one-entry output buffer and a one-entry input buffer, mapped as four processor-visible registers.
- Injects packets into the router (router pesi/peri/pedi) on the virtual channel matching the router's polarity.
- Accepts ejected packets from the router (router peso/pero/pedo) with the same send/ready handshake.

---
 rtl/ring_nic_if.sv | 28 ++
 rtl/ring_nic.sv | 76 +++++++
 tb/tb_ring_nic.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ring_nic_if.sv
// Processor register bus and ring-router PE port of the ring NIC.
// The master side is the PE plus router; the slave side is the NIC.
interface ring_nic_if #(
  parameter int unsigned DATA_W = 64
);
  logic [1:0]        addr;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              nicEn;
  logic              nicWrEn;
  logic              net_polarity;
  logic              net_so;
  logic              net_ro;
  logic [DATA_W-1:0] net_do;
  logic              net_si;
  logic              net_ri;
  logic [DATA_W-1:0] net_di;

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_polarity, net_ro, net_si, net_di,
    input  d_out, net_so, net_do, net_ri
  );

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_polarity, net_ro, net_si, net_di,
    output d_out, net_so, net_do, net_ri
  );
endinterface

// File: rtl/ring_nic.sv
// Ring NIC: one-entry output and input buffers behind four processor registers,
// injecting on the VC matching router polarity and accepting ejected packets.
module ring_nic #(
  parameter int unsigned DATA_W = 64
) (
  input logic       clk,
  input logic       reset,
  ring_nic_if.slave bus
);
  localparam int unsigned VcBit = DATA_W - 1;

  logic [DATA_W-1:0] out_buf_q, out_buf_d;
  logic [DATA_W-1:0] in_buf_q, in_buf_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              out_full_q, out_full_d;
  logic              in_full_q, in_full_d;
  logic              wr_out, rd, send, recv;

  assign wr_out = bus.nicEn & bus.nicWrEn & (bus.addr == 2'b10);
  assign rd     = bus.nicEn & ~bus.nicWrEn;
  assign send   = out_full_q & bus.net_ro & (out_buf_q[VcBit] == bus.net_polarity) & ~reset;
  assign recv   = bus.net_si & bus.net_ri;

  assign bus.net_so = send;
  assign bus.net_do = out_buf_q;
  assign bus.net_ri = ~in_full_q & ~reset;
  assign bus.d_out  = d_out_q;

  always_comb begin
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    d_out_d    = d_out_q;

    if (send) out_full_d = 1'b0;
    // Fullness is judged before this edge's drain, so a write racing a send is dropped.
    if (wr_out && !out_full_q) begin
      out_buf_d  = bus.d_in;
      out_full_d = 1'b1;
    end

    if (rd) begin
      unique case (bus.addr)
        2'b00: begin
          d_out_d   = in_buf_q;
          in_full_d = 1'b0;
        end
        2'b01: d_out_d = {{(DATA_W-1){1'b0}}, in_full_q};
        2'b10: d_out_d = '0;
        2'b11: d_out_d = {{(DATA_W-1){1'b0}}, out_full_q};
      endcase
    end

    if (recv) begin
      in_buf_d  = bus.net_di;
      in_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      d_out_q    <= '0;
    end else begin
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      d_out_q    <= d_out_d;
    end
  end
endmodule

// File: tb/tb_ring_nic.sv
// Bench for ring_nic: directed scenarios followed by random traffic, all
// compared against a queue-based model of the two one-entry buffers.
module tb_ring_nic;
  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic reset;
  ring_nic_if #(.DATA_W(W)) bus ();
  ring_nic #(.DATA_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         t_rst, t_en, t_wr, t_pol, t_ro, t_si;
  logic [1:0]   t_addr;
  logic [W-1:0] t_din, t_di;

  logic [W-1:0] out_q[$];
  logic [W-1:0] in_q[$];
  logic [W-1:0] m_out_data, m_in_data, m_dout;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic en, input logic wr, input logic [1:0] a, input logic [W-1:0] d);
    t_en = en; t_wr = wr; t_addr = a; t_din = d;
  endtask

  // One clock: drive, check combinational outputs, advance model, check d_out.
  task automatic cycle();
    logic exp_so, exp_ri, was_empty;
    reset = t_rst;
    bus.addr = t_addr; bus.d_in = t_din; bus.nicEn = t_en; bus.nicWrEn = t_wr;
    bus.net_polarity = t_pol; bus.net_ro = t_ro; bus.net_si = t_si; bus.net_di = t_di;
    #1;
    exp_so = !t_rst && out_q.size() != 0 && t_ro && (out_q[0][W-1] == t_pol);
    exp_ri = !t_rst && in_q.size() == 0;
    check("net_so", {63'b0, bus.net_so}, {63'b0, exp_so});
    check("net_ri", {63'b0, bus.net_ri}, {63'b0, exp_ri});
    if (!t_rst) check("net_do", bus.net_do, m_out_data);

    if (t_rst) begin
      out_q.delete(); in_q.delete();
      m_out_data = '0; m_in_data = '0; m_dout = '0;
    end else begin
      was_empty = (out_q.size() == 0);
      if (t_en && !t_wr) begin
        case (t_addr)
          2'd0: begin
            m_dout = m_in_data;
            if (in_q.size() != 0) void'(in_q.pop_front());
          end
          2'd1: m_dout = W'(in_q.size());
          2'd2: m_dout = '0;
          default: m_dout = W'(out_q.size());
        endcase
      end
      if (exp_so) void'(out_q.pop_front());
      if (t_en && t_wr && t_addr == 2'd2 && was_empty) begin
        out_q.push_back(t_din);
        m_out_data = t_din;
      end
      if (exp_ri && t_si) begin
        in_q.push_back(t_di);
        m_in_data = t_di;
      end
    end

    @(posedge clk);
    #1;
    check("d_out", bus.d_out, m_dout);
    @(negedge clk);
    t_pol = ~t_pol;
  endtask

  initial begin
    t_rst = 1'b1; t_pol = 1'b0; t_ro = 1'b0; t_si = 1'b1; t_di = 64'hDEAD;
    acc(1'b0, 1'b0, 2'd0, '0);
    m_out_data = '0; m_in_data = '0; m_dout = '0;
    @(negedge clk);

    // Reset held with a packet offered
    repeat (3) cycle();
    check("rst_d_out", bus.d_out, 64'h0);
    t_rst = 1'b0; t_si = 1'b0;
    acc(1'b1, 1'b0, 2'd1, '0); cycle();
    check("rst_in_status", bus.d_out, 64'h0);
    acc(1'b1, 1'b0, 2'd3, '0); cycle();
    check("rst_out_status", bus.d_out, 64'h0);

    // Even-VC injection
    t_ro = 1'b1;
    acc(1'b1, 1'b1, 2'd2, 64'h0000_0000_0000_00A5); cycle();
    acc(1'b0, 1'b0, 2'd0, '0); repeat (3) cycle();
    check("inj_net_do", bus.net_do, 64'hA5);
    acc(1'b1, 1'b0, 2'd3, '0); cycle();
    check("inj_status", bus.d_out, 64'h0);

    // Odd VC under backpressure; second write dropped
    t_ro = 1'b0;
    acc(1'b1, 1'b1, 2'd2, 64'h8000_0000_0000_0001); cycle();
    acc(1'b0, 1'b0, 2'd0, '0); repeat (2) cycle();
    acc(1'b1, 1'b1, 2'd2, 64'h2); cycle();
    acc(1'b0, 1'b0, 2'd0, '0);
    t_ro = 1'b1; repeat (3) cycle();
    check("odd_net_do", bus.net_do, 64'h8000_0000_0000_0001);
    acc(1'b1, 1'b0, 2'd3, '0); cycle();
    check("odd_status", bus.d_out, 64'h0);

    // Ejection, then a second packet held while full
    acc(1'b0, 1'b0, 2'd0, '0);
    t_si = 1'b1; t_di = 64'h4000_0000_0000_BEEF; cycle();
    t_di = 64'h7;
    acc(1'b1, 1'b0, 2'd1, '0); cycle();
    check("ej_status", bus.d_out, 64'h1);
    acc(1'b1, 1'b0, 2'd0, '0); cycle();
    check("ej_data", bus.d_out, 64'h4000_0000_0000_BEEF);
    acc(1'b0, 1'b0, 2'd0, '0); cycle();
    t_si = 1'b0;
    acc(1'b1, 1'b0, 2'd0, '0); cycle();
    check("ej_held_data", bus.d_out, 64'h7);

    // Reset with both buffers full
    t_ro = 1'b0; t_si = 1'b1; t_di = 64'h55;
    acc(1'b1, 1'b1, 2'd2, 64'h0123); cycle();
    t_si = 1'b0; acc(1'b0, 1'b0, 2'd0, '0); cycle();
    t_rst = 1'b1; cycle();
    t_rst = 1'b0; t_ro = 1'b1;
    acc(1'b1, 1'b0, 2'd1, '0); cycle();
    check("mid_rst_in_status", bus.d_out, 64'h0);
    acc(1'b1, 1'b0, 2'd3, '0); cycle();
    check("mid_rst_out_status", bus.d_out, 64'h0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      t_rst = ($urandom_range(0, 59) == 0);
      t_ro  = ($urandom_range(0, 3) != 0);
      t_si  = $urandom_range(0, 1);
      t_di  = {$urandom(), $urandom()};
      acc($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
          {$urandom(), $urandom()});
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
